// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that drives a shared bank of JK flip-flops
// for count+1 edges per command and mirrors the bank Q.
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] mask0,
    input  logic [CNTW-1:0]  count0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask1,
    input  logic [CNTW-1:0]  count1,
    output logic             gnt1,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q_shadow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RELEASE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_nx;
    logic             prio1;
    logic             prio1_nx;
    logic [WIDTH-1:0] j_nx;
    logic [WIDTH-1:0] k_nx;
    logic [WIDTH-1:0] q_nx;
    logic             gnt0_nx;
    logic             gnt1_nx;
    logic             done_nx;

    logic             pick1;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;
    logic [CNTW-1:0]  sel_count;
    logic [WIDTH-1:0] enc_j;
    logic [WIDTH-1:0] enc_k;

    // prio1 set means requester 1 wins the next tie
    always_comb begin
        pick1     = req1 & (~req0 | prio1);
        sel_op    = pick1 ? op1 : op0;
        sel_mask  = pick1 ? mask1 : mask0;
        sel_count = pick1 ? count1 : count0;
    end

    always_comb begin
        enc_j = '0;
        enc_k = '0;
        unique case (sel_op)
            2'b01: enc_k = sel_mask;
            2'b10: enc_j = sel_mask;
            2'b11: begin
                enc_j = sel_mask;
                enc_k = sel_mask;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        prio1_nx = prio1;
        j_nx     = j_out;
        k_nx     = k_out;
        q_nx     = q_shadow;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nx = APPLY;
                    cnt_nx   = sel_count;
                    j_nx     = enc_j;
                    k_nx     = enc_k;
                    gnt0_nx  = ~pick1;
                    gnt1_nx  = pick1;
                    prio1_nx = ~pick1;
                end
            end
            APPLY: begin
                q_nx = (j_out & ~q_shadow) | (~k_out & q_shadow);
                if (cnt != '0) begin
                    cnt_nx = cnt - CNTW'(1);
                end else begin
                    state_nx = RELEASE;
                    j_nx     = '0;
                    k_nx     = '0;
                    done_nx  = 1'b1;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            prio1    <= 1'b0;
            j_out    <= '0;
            k_out    <= '0;
            q_shadow <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            prio1    <= prio1_nx;
            j_out    <= j_nx;
            k_out    <= k_nx;
            q_shadow <= q_nx;
            gnt0     <= gnt0_nx;
            gnt1     <= gnt1_nx;
            done     <= done_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Randomized bench for jk_bank_arbiter against a
// command-level model of the JK bank and round-robin.
module tb_jk_bank_arbiter;

    logic       clock;
    logic       reset;
    logic       req0;
    logic [1:0] op0;
    logic [7:0] mask0;
    logic [3:0] count0;
    logic       gnt0;
    logic       req1;
    logic [1:0] op1;
    logic [7:0] mask1;
    logic [3:0] count1;
    logic       gnt1;
    logic [7:0] j_out;
    logic [7:0] k_out;
    logic [7:0] q_shadow;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_bad;
    logic [7:0] mq;
    int last;

    jk_bank_arbiter #(.WIDTH(8), .CNTW(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .op0(op0), .mask0(mask0),
        .count0(count0), .gnt0(gnt0),
        .req1(req1), .op1(op1), .mask1(mask1),
        .count1(count1), .gnt1(gnt1),
        .j_out(j_out), .k_out(k_out),
        .q_shadow(q_shadow), .busy(busy), .done(done)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] ej(logic [1:0] op, logic [7:0] m);
        return op[1] ? m : 8'h00;
    endfunction

    function automatic logic [7:0] ek(logic [1:0] op, logic [7:0] m);
        return op[0] ? m : 8'h00;
    endfunction

    // bank contents after n applied edges of one command
    function automatic logic [7:0] q_after(logic [7:0] q,
            logic [1:0] op, logic [7:0] m, int n);
        case (op)
            2'b01: return q & ~m;
            2'b10: return q | m;
            2'b11: return (n % 2 == 1) ? (q ^ m) : q;
            default: return q;
        endcase
    endfunction

    // entered at a negedge with the DUT idle; returns the same way
    task automatic test_command(input bit a0, input bit a1,
            input logic [1:0] o0, input logic [7:0] m0,
            input logic [3:0] c0, input logic [1:0] o1,
            input logic [7:0] m1, input logic [3:0] c1);
        int w;
        logic [1:0] op;
        logic [7:0] m;
        logic [3:0] c;
        logic [7:0] q0;
        logic [7:0] qe;
        if (a0 && a1) w = 1 - last;
        else w = a1 ? 1 : 0;
        op = w ? o1 : o0;
        m  = w ? m1 : m0;
        c  = w ? c1 : c0;
        q0 = mq;
        req0 = a0; op0 = o0; mask0 = m0; count0 = c0;
        req1 = a1; op1 = o1; mask1 = m1; count1 = c1;
        @(negedge clock);
        n_cmp++;
        if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL grant: got %b want %0d",
                     {gnt1, gnt0}, w);
        end
        n_cmp++;
        if ({j_out, k_out} !== {ej(op, m), ek(op, m)}) begin
            n_bad++;
            $display("FAIL jk_load: got %h/%h want %h/%h",
                     j_out, k_out, ej(op, m), ek(op, m));
        end
        n_cmp++;
        if ({busy, done, q_shadow} !== {2'b10, q0}) begin
            n_bad++;
            $display("FAIL first_apply: got b%b d%b q%h want 1 0 %h",
                     busy, done, q_shadow, q0);
        end
        req0 = 0;
        req1 = 0;
        last = w;
        for (int i = 1; i <= int'(c) + 1; i++) begin
            @(negedge clock);
            qe = q_after(q0, op, m, i);
            n_cmp++;
            if (q_shadow !== qe) begin
                n_bad++;
                $display("FAIL q_step%0d: got %h want %h",
                         i, q_shadow, qe);
            end
            n_cmp++;
            if (i <= int'(c)) begin
                if ({gnt0, gnt1, busy, done, j_out, k_out}
                    !== {4'b0010, ej(op, m), ek(op, m)}) begin
                    n_bad++;
                    $display("FAIL apply%0d: g%b%b b%b d%b j%h k%h",
                             i, gnt0, gnt1, busy, done, j_out, k_out);
                end
            end else begin
                if ({gnt0, gnt1, busy, done, j_out, k_out}
                    !== {4'b0011, 16'h0000}) begin
                    n_bad++;
                    $display("FAIL release: g%b%b b%b d%b j%h k%h want 0011 0 0",
                             gnt0, gnt1, busy, done, j_out, k_out);
                end
            end
        end
        @(negedge clock);
        mq = q_after(q0, op, m, int'(c) + 1);
        n_cmp++;
        if ({busy, done, gnt0, gnt1, q_shadow} !== {4'b0000, mq}) begin
            n_bad++;
            $display("FAIL idle_after: b%b d%b g%b%b q%h want 0000 %h",
                     busy, done, gnt0, gnt1, q_shadow, mq);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        req0 = 0; op0 = 0; mask0 = 0; count0 = 0;
        req1 = 0; op1 = 0; mask1 = 0; count1 = 0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({busy, done, gnt0, gnt1, j_out, k_out, q_shadow}
            !== 28'h0) begin
            n_bad++;
            $display("FAIL reset: b%b d%b g%b%b j%h k%h q%h want 0",
                     busy, done, gnt0, gnt1, j_out, k_out, q_shadow);
        end
        reset = 0;
        mq = 0;
        last = 1;
    endtask

    task automatic test_round_robin();
        int gcyc[$];
        int gwho[$];
        req0 = 1; op0 = 0; mask0 = 8'hA5; count0 = 0;
        req1 = 1; op1 = 0; mask1 = 8'h5A; count1 = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clock);
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                gcyc.push_back(t);
                gwho.push_back(gnt1 === 1'b1 ? 1 : 0);
            end
        end
        req0 = 0;
        req1 = 0;
        n_cmp++;
        if (gcyc.size() != 4) begin
            n_bad++;
            $display("FAIL rr_count: got %0d grants want 4",
                     gcyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (gcyc[k] != 1 + 3 * k || gwho[k] != k % 2) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: cyc %0d req %0d want %0d %0d",
                             k, gcyc[k], gwho[k], 1 + 3 * k, k % 2);
                end
            end
        end
        last = 1;
        @(negedge clock);
        n_cmp++;
        if ({busy, q_shadow} !== {1'b0, mq}) begin
            n_bad++;
            $display("FAIL rr_end: b%b q%h want 0 %h", busy, q_shadow, mq);
        end
    endtask

    task automatic test_reset_mid_apply();
        bit saw_done;
        saw_done = 0;
        req0 = 1; op0 = 2'b11; mask0 = 8'hFF; count0 = 4'd5;
        @(negedge clock);
        req0 = 0;
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1;
        #1;
        n_cmp++;
        if ({busy, done, gnt0, gnt1, j_out, k_out, q_shadow}
            !== 28'h0) begin
            n_bad++;
            $display("FAIL abort: b%b d%b g%b%b j%h k%h q%h want 0",
                     busy, done, gnt0, gnt1, j_out, k_out, q_shadow);
        end
        @(negedge clock);
        reset = 0;
        mq = 0;
        last = 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1;
            n_cmp++;
            if ({busy, gnt0, gnt1, q_shadow} !== 11'h0) begin
                n_bad++;
                $display("FAIL post_abort%0d: b%b g%b%b q%h want 0",
                         t, busy, gnt0, gnt1, q_shadow);
            end
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL abort_done: got pulse want none");
        end
    endtask

    task automatic test_random();
        bit a0;
        bit a1;
        for (int n = 0; n < 24; n++) begin
            a0 = 1'($urandom_range(0, 1));
            a1 = a0 ? 1'($urandom_range(0, 1)) : 1'b1;
            test_command(a0, a1,
                2'($urandom), 8'($urandom), 4'($urandom_range(0, 6)),
                2'($urandom), 8'($urandom), 4'($urandom_range(0, 6)));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        @(negedge clock);
        test_command(1, 0, 2'b10, 8'h0F, 0, 0, 0, 0);
        test_command(0, 1, 0, 0, 0, 2'b11, 8'hFF, 2);
        test_command(1, 0, 2'b10, 8'hFF, 0, 0, 0, 0);
        test_command(1, 0, 2'b01, 8'h3C, 0, 0, 0, 0);
        test_command(0, 1, 0, 0, 0, 2'b00, 8'hFF, 1);
        test_reset();
        @(negedge clock);
        test_round_robin();
        test_command(1, 1, 2'b10, 8'h81, 1, 2'b10, 8'h18, 0);
        test_command(1, 1, 2'b11, 8'hF0, 2, 2'b01, 8'h0F, 0);
        test_reset_mid_apply();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
